// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// One idle arbitration cycle per transaction, grant held until RAM ACCESS or owner abort.
module ram_port_arbiter #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NREQ-1:0]        req_ren,
  input  logic [NREQ-1:0]        req_wen,
  input  logic [NREQ*WORD_W-1:0] req_addr,
  input  logic [NREQ*WORD_W-1:0] req_store,
  output logic [NREQ-1:0]        req_wait,
  output logic [WORD_W-1:0]      req_load,
  output logic [NREQ-1:0]        grant,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic [15:0]            xfer_count
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   owner, owner_nx, rr_ptr, rr_ptr_nx, pick, owner_inc;
  logic [IW:0]     idx;
  logic            found, cnt_inc, rd;
  logic [NREQ-1:0] active;
  logic [WORD_W-1:0] addr_arr  [NREQ];
  logic [WORD_W-1:0] store_arr [NREQ];

  assign active = req_ren | req_wen;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*WORD_W +: WORD_W];
    assign store_arr[g] = req_store[g*WORD_W +: WORD_W];
  end

  assign owner_inc = (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;

  // First active requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (!found && active[idx[IW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    rr_ptr_nx = rr_ptr;
    cnt_inc   = 1'b0;
    rd        = 1'b0;
    grant     = '0;
    req_wait  = '1;
    req_load  = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          owner_nx = pick;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        rd              = req_ren[owner] & ~req_wen[owner];
        grant[owner]    = 1'b1;
        ramaddr         = addr_arr[owner];
        ramstore        = store_arr[owner];
        ramWEN          = req_wen[owner];
        ramREN          = rd;
        req_wait[owner] = (ramstate != ACCESS);
        if (ramstate == ACCESS) begin
          if (rd) req_load = ramload;
          state_nx  = IDLE;
          rr_ptr_nx = owner_inc;
          cnt_inc   = 1'b1;
        end else if (!active[owner]) begin
          // owner withdrew: release the port without counting a transfer
          state_nx  = IDLE;
          rr_ptr_nx = owner_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      owner      <= '0;
      rr_ptr     <= '0;
      xfer_count <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      rr_ptr <= rr_ptr_nx;
      if (cnt_inc) xfer_count <= xfer_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level reference model of owner, round-robin pointer and count.
module tb_ram_port_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  logic [N-1:0]   req_ren, req_wen, req_wait, grant;
  logic [N*W-1:0] req_addr, req_store;
  logic [W-1:0]   req_load, ramaddr, ramstore, ramload;
  logic           ramREN, ramWEN;
  logic [1:0]     ramstate;
  logic [15:0]    xfer_count;

  always #5 CLK = ~CLK;

  ram_port_arbiter #(.NREQ(N), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen),
    .req_addr(req_addr), .req_store(req_store), .req_wait(req_wait),
    .req_load(req_load), .grant(grant), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
    .ramstate(ramstate), .xfer_count(xfer_count)
  );

  int total = 0;
  int bad   = 0;
  int m_own;           // -1 when the port is free
  int m_ptr;
  int m_cnt;
  logic [N-1:0] gq [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] word(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic check_outs();
    logic [N-1:0] e_grant, e_wait;
    logic e_ren, e_wen;
    logic [W-1:0] e_addr, e_store, e_load;
    e_grant = '0; e_wait = '1; e_ren = 0; e_wen = 0;
    e_addr = '0; e_store = '0; e_load = '0;
    if (m_own >= 0) begin
      e_grant[m_own] = 1'b1;
      e_wen   = req_wen[m_own];
      e_ren   = req_ren[m_own] && !req_wen[m_own];
      e_addr  = word(req_addr, m_own);
      e_store = word(req_store, m_own);
      e_wait[m_own] = (ramstate != ACCESS);
      if (e_ren && ramstate == ACCESS) e_load = ramload;
    end
    chk("grant",    64'(grant),    64'(e_grant));
    chk("req_wait", 64'(req_wait), 64'(e_wait));
    chk("ramREN",   64'(ramREN),   64'(e_ren));
    chk("ramWEN",   64'(ramWEN),   64'(e_wen));
    chk("ramaddr",  64'(ramaddr),  64'(e_addr));
    chk("ramstore", 64'(ramstore), 64'(e_store));
    chk("req_load", 64'(req_load), 64'(e_load));
    chk("xfer_count", 64'(xfer_count), 64'(m_cnt));
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req_ren[i] || req_wen[i]) begin
          m_own = i;
          break;
        end
      end
    end else if (ramstate == ACCESS) begin
      m_ptr = (m_own + 1) % N;
      m_cnt = (m_cnt + 1) % 65536;
      m_own = -1;
    end else if (!(req_ren[m_own] || req_wen[m_own])) begin
      m_ptr = (m_own + 1) % N;
      m_own = -1;
    end
  endtask

  // Called at posedge+1; checks mid-cycle, then steps model across the edge.
  task automatic tick();
    #3;
    check_outs();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  initial begin
    logic [N-1:0] on;
    nRST = 1'b0;
    req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    ramload = '0; ramstate = FREE;
    model_reset();
    #1;
    check_outs();
    @(posedge CLK); #1;
    nRST = 1'b1;

    // idle
    repeat (10) tick();

    // all four continuously requesting, ACCESS one cycle after each grant
    req_ren = '1;
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = $urandom;
    for (int c = 0; c < 20 && gq.size() < 5; c++) begin
      ramstate = (m_own >= 0) ? ACCESS : FREE;
      ramload  = $urandom;
      tick();
      if (grant != '0) gq.push_back(grant);
    end
    chk("rr_count", 64'(gq.size()), 64'd5);
    if (gq.size() == 5) begin
      chk("rr0", 64'(gq[0]), 64'b0001);
      chk("rr1", 64'(gq[1]), 64'b0010);
      chk("rr2", 64'(gq[2]), 64'b0100);
      chk("rr3", 64'(gq[3]), 64'b1000);
      chk("rr4", 64'(gq[4]), 64'b0001);
    end
    ramstate = ACCESS; tick();
    req_ren = '0; ramstate = FREE; tick();

    // single read from requester 2, ACCESS after three cycles
    req_ren[2] = 1'b1;
    req_addr[2*W +: W] = 32'h0000_0040;
    tick();
    chk("rd_grant", 64'(grant), 64'b0100);
    ramstate = BUSY; tick(); tick();
    ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #3;
    chk("rd_load", 64'(req_load), 64'hDEAD_BEEF);
    chk("rd_addr", 64'(ramaddr), 64'h40);
    #2; @(posedge CLK); model_step(); #1;
    req_ren = '0; ramstate = FREE; tick();
    chk("rd_count", 64'(xfer_count), 64'd6);

    // simultaneous ren and wen: write wins
    req_ren[1] = 1'b1; req_wen[1] = 1'b1;
    req_addr[1*W +: W] = 32'h100; req_store[1*W +: W] = 32'h1234_5678;
    tick();
    ramstate = BUSY;
    #3;
    chk("rw_wen", 64'(ramWEN), 64'd1);
    chk("rw_ren", 64'(ramREN), 64'd0);
    chk("rw_store", 64'(ramstore), 64'h1234_5678);
    #2; @(posedge CLK); model_step(); #1;
    ramstate = ACCESS; tick();
    req_ren = '0; req_wen = '0; ramstate = FREE; tick();

    // abort: requester 0 granted then drops during BUSY
    req_ren[0] = 1'b1; tick();
    ramstate = BUSY; tick();
    req_ren[0] = 1'b0; tick();
    chk("ab_idle", 64'(grant), 64'd0);
    chk("ab_count", 64'(xfer_count), 64'd7);
    req_ren = 4'b1011; tick();
    chk("ab_next", 64'(grant), 64'b0010);
    ramstate = ACCESS; tick();
    req_ren = '0; ramstate = FREE; tick();

    // ERROR is not completion
    req_wen[3] = 1'b1; req_store[3*W +: W] = $urandom; tick();
    ramstate = ERROR;
    repeat (5) tick();
    ramstate = ACCESS; tick();
    req_wen = '0; ramstate = FREE; tick();
    chk("err_count", 64'(xfer_count), 64'd9);

    // reset asserted mid-GRANT
    req_ren[0] = 1'b1; tick();
    ramstate = BUSY; tick();
    #2; nRST = 1'b0; model_reset(); #1;
    check_outs();
    chk("rst_ren", 64'(ramREN), 64'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    req_ren = '0; ramstate = FREE;

    // random traffic
    on = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (on[i]) begin
          if ($urandom_range(9) == 0) on[i] = 1'b0;
        end else if ($urandom_range(9) < 3) begin
          on[i] = 1'b1;
          req_addr[i*W +: W]  = $urandom;
          req_store[i*W +: W] = $urandom;
        end
        req_ren[i] = on[i] && ($urandom_range(3) != 0);
        req_wen[i] = on[i] && !req_ren[i] ? 1'b1 : (on[i] && $urandom_range(7) == 0);
      end
      case ($urandom_range(19))
        0, 1, 2, 3, 4, 5, 6, 7: ramstate = ACCESS;
        8, 9, 10, 11, 12, 13:   ramstate = BUSY;
        14, 15, 16:             ramstate = FREE;
        default:                ramstate = ERROR;
      endcase
      ramload = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
